// File: rtl/mem_cmd_pkg.sv
// Shared encodings for the memory command controller: FSM states, key indices, widths.
package mem_cmd_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_KEYS = 4;

    localparam int KEY_CLR  = 0;
    localparam int KEY_WR   = 1;
    localparam int KEY_RD   = 2;
    localparam int KEY_ADDR = 3;

    // IDLE is deliberately not the all-zero code.
    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WR_REQ    = 3'd2,
        ST_RD_REQ    = 3'd3,
        ST_ADDR_STEP = 3'd4
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, stable-level counter and a 1-cycle pulse on each debounced press.
module key_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter only runs while the synchronised level disagrees with the
    // debounced one; any return to agreement restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                cnt_q   <= '0;
                db_q    <= sync2_q;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mem_cmd_ctrl.sv
// Key-driven memory command sequencer. Define MEM_CMD_TIMEOUT_EN to add the
// request timeout and sticky err flag; without it requests wait for ack forever.
module mem_cmd_ctrl
    import mem_cmd_pkg::*;
#(
    parameter int DB_CYCLES      = 50000,
    parameter int ADDR_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [3:0]        key_n,
    input  logic              mem_ack,
    output logic              mem_wr_req,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] wr_cnt,
    output logic [DATA_W-1:0] rd_cnt,
    output logic              busy,
    output logic              err
);

    localparam logic [DATA_W-1:0] ADDR_INC = DATA_W'(ADDR_STEP);

    state_e              state_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_cnt_q;
    logic [DATA_W-1:0]   rd_cnt_q;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] pend_q;
    logic [NUM_KEYS-1:0] pend_d;
    logic [NUM_KEYS-1:0] pend_clr;
    logic                in_req;
    logic                tmo_hit;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i  (sys_clk),
            .rst_i  (rst),
            .key_n_i(key_n[i]),
            .press_o(press[i])
        );
    end

    assign in_req = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);

    always_comb begin
        pend_clr = '0;
        case (state_q)
            ST_CLEAR:     pend_clr[KEY_CLR]  = 1'b1;
            ST_WR_REQ:    pend_clr[KEY_WR]   = mem_ack | tmo_hit;
            ST_RD_REQ:    pend_clr[KEY_RD]   = mem_ack | tmo_hit;
            ST_ADDR_STEP: pend_clr[KEY_ADDR] = 1'b1;
            default:      pend_clr           = '0;
        endcase
    end

    // A fresh press in the same cycle as the clear keeps the command pending.
    assign pend_d = (pend_q & ~pend_clr) | press;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            pend_q   <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q[KEY_CLR])       state_q <= ST_CLEAR;
                    else if (pend_q[KEY_WR])   state_q <= ST_WR_REQ;
                    else if (pend_q[KEY_RD])   state_q <= ST_RD_REQ;
                    else if (pend_q[KEY_ADDR]) state_q <= ST_ADDR_STEP;
                end
                ST_CLEAR: begin
                    addr_q   <= '0;
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                    state_q  <= ST_IDLE;
                end
                ST_WR_REQ: begin
                    if (mem_ack) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ack) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADDR_STEP: begin
                    addr_q  <= addr_q + ADDR_INC;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // tmo_q counts request cycles already spent; ack in the last cycle still wins.
    assign tmo_hit = in_req && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (in_req && !mem_ack && !tmo_hit) ? tmo_q + 1'b1 : '0;
            if (state_q == ST_CLEAR)        err_q <= 1'b0;
            else if (tmo_hit && !mem_ack)   err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    // No timeout hardware: the flag can never be raised.
    assign err     = (TIMEOUT_CYCLES < 0);
`endif

    assign mem_wr_req = (state_q == ST_WR_REQ);
    assign mem_rd_req = (state_q == ST_RD_REQ);
    assign busy       = (state_q != ST_IDLE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wr_cnt_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;

endmodule
